// File: rtl/mem_access_ctrl_if.sv
// Request/strobe bundle between the CPU requesters, the shared memory block
// and the memory access controller.
interface mem_access_ctrl_if;
  logic        if_req;
  logic        d_req;
  logic        d_we;
  logic [31:0] mem_dout;
  logic        IorD;
  logic        MemRead;
  logic        MemWrite;
  logic        IRWrite;
  logic        if_done;
  logic        d_done;
  logic [31:0] d_rdata;
  logic        busy;

  // Requester/memory side of the bundle.
  modport master (
    output if_req, d_req, d_we, mem_dout,
    input  IorD, MemRead, MemWrite, IRWrite, if_done, d_done, d_rdata, busy
  );

  // Controller side of the bundle.
  modport slave (
    input  if_req, d_req, d_we, mem_dout,
    output IorD, MemRead, MemWrite, IRWrite, if_done, d_done, d_rdata, busy
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Sequencing controller for the shared single-port instruction/data memory:
// arbitrates fetch vs load/store, drives the memory strobes and owns the MDR.
module mem_access_ctrl #(
  parameter int RD_LATENCY   = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  mem_access_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, FETCH, DREAD, DWRITE} state_t;

  localparam logic [2:0] LAT_INIT   = 3'(RD_LATENCY);
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  state_t      state_q, state_d;
  logic [2:0]  lat_cnt_q, lat_cnt_d;
  logic [3:0]  starve_cnt_q, starve_cnt_d;
  logic [31:0] d_rdata_q;
  logic        last_cycle;
  logic        starved;

  // Read data is valid once the latency counter has run down to zero.
  assign last_cycle = (lat_cnt_q == 3'd0);
  assign starved    = (starve_cnt_q == STARVE_MAX);

  // State register.
  // NOTE: clocked blocks use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      lat_cnt_q    <= 3'd0;
      starve_cnt_q <= 4'd0;
    end else begin
      state_q      <= state_d;
      lat_cnt_q    <= lat_cnt_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  // MDR: captures the load word on the closing edge of the last DREAD cycle.
  // NOTE: the MDR is one register, not an array, so it takes a defined reset value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_rdata_q <= 32'd0;
    end else if (state_q == DREAD && last_cycle) begin
      d_rdata_q <= bus.mem_dout;
    end
  end

  // Next-state and arbitration. Requests only matter while IDLE.
  // NOTE: every signal gets a default first so no path infers a latch.
  always_comb begin
    state_d      = state_q;
    lat_cnt_d    = lat_cnt_q;
    starve_cnt_d = starve_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.if_req && (!bus.d_req || starved)) begin
          state_d      = FETCH;
          lat_cnt_d    = LAT_INIT;
          starve_cnt_d = 4'd0;
        end else if (bus.d_req) begin
          state_d   = bus.d_we ? DWRITE : DREAD;
          lat_cnt_d = LAT_INIT;
          if (!bus.if_req) begin
            starve_cnt_d = 4'd0;
          end else if (!starved) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
          end
        end else begin
          starve_cnt_d = 4'd0;
        end
      end
      FETCH, DREAD: begin
        if (last_cycle) begin
          state_d = IDLE;
        end else begin
          lat_cnt_d = lat_cnt_q - 3'd1;
        end
      end
      DWRITE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode from state and latency counter only.
  always_comb begin
    bus.IorD     = 1'b0;
    bus.MemRead  = 1'b0;
    bus.MemWrite = 1'b0;
    bus.IRWrite  = 1'b0;
    bus.if_done  = 1'b0;
    bus.d_done   = 1'b0;
    unique case (state_q)
      FETCH: begin
        bus.MemRead = 1'b1;
        bus.IRWrite = last_cycle;
        bus.if_done = last_cycle;
      end
      DREAD: begin
        bus.IorD    = 1'b1;
        bus.MemRead = 1'b1;
        bus.d_done  = last_cycle;
      end
      DWRITE: begin
        bus.IorD     = 1'b1;
        bus.MemWrite = 1'b1;
        bus.d_done   = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.busy    = (state_q != IDLE);
  assign bus.d_rdata = d_rdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: three instances (RD_LATENCY 1..3) share one
// directed stimulus and are compared each cycle against a transaction model.
module tb_mem_access_ctrl;

  localparam int NL = 3;
  localparam int SL = 4;
  localparam int K_IDLE  = 0;
  localparam int K_FETCH = 1;
  localparam int K_READ  = 2;
  localparam int K_WRITE = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        if_req = 1'b0;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] mem_dout = 32'd0;

  always #5 clk = ~clk;

  logic [NL-1:0] act_iord, act_mrd, act_mwr, act_irw, act_ifd, act_dd, act_busy;
  logic [31:0]   act_rdata [NL];

  for (genvar g = 0; g < NL; g++) begin : g_lane
    mem_access_ctrl_if bus();
    assign bus.if_req   = if_req;
    assign bus.d_req    = d_req;
    assign bus.d_we     = d_we;
    assign bus.mem_dout = mem_dout;

    mem_access_ctrl #(.RD_LATENCY(g + 1), .STARVE_LIMIT(SL)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
    );

    assign act_iord[g]  = bus.IorD;
    assign act_mrd[g]   = bus.MemRead;
    assign act_mwr[g]   = bus.MemWrite;
    assign act_irw[g]   = bus.IRWrite;
    assign act_ifd[g]   = bus.if_done;
    assign act_dd[g]    = bus.d_done;
    assign act_busy[g]  = bus.busy;
    assign act_rdata[g] = bus.d_rdata;
  end

  // Transaction model: what each lane is doing and how many cycles it has run.
  int          m_kind   [NL];
  int          m_age    [NL];
  int          m_starve [NL];
  logic [31:0] m_mdr    [NL];

  // Grant order seen on the DUT outputs (1 = fetch), first ten grants only.
  logic [31:0]   glog [NL];
  int            gcnt [NL];
  logic [NL-1:0] prev_busy;

  int checks = 0;
  int errors = 0;

  function automatic int lat(input int l);
    return l + 1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int l = 0; l < NL; l++) begin
      m_kind[l]   = K_IDLE;
      m_age[l]    = 0;
      m_starve[l] = 0;
      m_mdr[l]    = 32'd0;
    end
  endtask

  // One clock edge of the model, using the request values the DUT just sampled.
  task automatic model_update();
    for (int l = 0; l < NL; l++) begin
      if (m_kind[l] == K_IDLE) begin
        m_age[l] = 0;
        if (if_req && (!d_req || m_starve[l] == SL)) begin
          m_kind[l]   = K_FETCH;
          m_starve[l] = 0;
        end else if (d_req) begin
          m_kind[l]   = d_we ? K_WRITE : K_READ;
          m_starve[l] = if_req ? ((m_starve[l] < SL) ? m_starve[l] + 1 : SL) : 0;
        end else begin
          m_starve[l] = 0;
        end
      end else if (m_kind[l] == K_WRITE || m_age[l] == lat(l)) begin
        if (m_kind[l] == K_READ) m_mdr[l] = mem_dout;
        m_kind[l] = K_IDLE;
      end else begin
        m_age[l] = m_age[l] + 1;
      end
    end
  endtask

  task automatic compare_all();
    for (int l = 0; l < NL; l++) begin
      logic e_f, e_r, e_w, e_last;
      e_f    = (m_kind[l] == K_FETCH);
      e_r    = (m_kind[l] == K_READ);
      e_w    = (m_kind[l] == K_WRITE);
      e_last = (m_age[l] == lat(l));
      check($sformatf("L%0d busy", l),     32'(act_busy[l]), 32'(m_kind[l] != K_IDLE));
      check($sformatf("L%0d IorD", l),     32'(act_iord[l]), 32'(e_r | e_w));
      check($sformatf("L%0d MemRead", l),  32'(act_mrd[l]),  32'(e_f | e_r));
      check($sformatf("L%0d MemWrite", l), 32'(act_mwr[l]),  32'(e_w));
      check($sformatf("L%0d IRWrite", l),  32'(act_irw[l]),  32'(e_f & e_last));
      check($sformatf("L%0d if_done", l),  32'(act_ifd[l]),  32'(e_f & e_last));
      check($sformatf("L%0d d_done", l),   32'(act_dd[l]),   32'(e_w | (e_r & e_last)));
      check($sformatf("L%0d d_rdata", l),  act_rdata[l],     m_mdr[l]);
      if (act_busy[l] && !prev_busy[l]) begin
        if (gcnt[l] < 10) glog[l] = {glog[l][30:0], ~act_iord[l]};
        gcnt[l]++;
      end
      prev_busy[l] = act_busy[l];
    end
  endtask

  task automatic drive(input logic ir, input logic dr, input logic we, input logic [31:0] dout);
    if_req   = ir;
    d_req    = dr;
    d_we     = we;
    mem_dout = dout;
  endtask

  task automatic sample();
    @(negedge clk);
    compare_all();
  endtask

  task automatic advance();
    @(posedge clk);
    if (rst_n) model_update();
    #1;
  endtask

  task automatic cyc(input logic ir, input logic dr, input logic we, input logic [31:0] dout);
    drive(ir, dr, we, dout);
    sample();
    advance();
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0, 32'd0);
    rst_n = 1'b0;
    model_reset();
    prev_busy = '0;
    for (int l = 0; l < NL; l++) begin
      glog[l] = 32'd0;
      gcnt[l] = 0;
    end
    sample();
    check("reset busy", 32'(act_busy), 32'(3'b000));
    check("reset d_rdata L2", act_rdata[2], 32'd0);
    advance();
    advance();
    rst_n = 1'b1;
  endtask

  initial begin
    #1;
    do_reset();

    // Fetch only; if_req held through lane 0's bubble so it re-fetches.
    drive(1'b1, 1'b0, 1'b0, 32'h1111_1111);
    sample(); check("S1 c0 busy", 32'(act_busy), 32'(3'b000)); advance();
    sample(); check("S1 c1 busy", 32'(act_busy), 32'(3'b111));
              check("S1 c1 MemRead", 32'(act_mrd), 32'(3'b111));
              check("S1 c1 IorD", 32'(act_iord), 32'(3'b000)); advance();
    sample(); check("S1 c2 if_done", 32'(act_ifd), 32'(3'b001));
              check("S1 c2 IRWrite", 32'(act_irw), 32'(3'b001)); advance();
    sample(); check("S1 c3 busy", 32'(act_busy), 32'(3'b110));
              check("S1 c3 if_done", 32'(act_ifd), 32'(3'b010)); advance();
    drive(1'b0, 1'b0, 1'b0, 32'h1111_1111);
    sample(); check("S1 c4 busy", 32'(act_busy), 32'(3'b101));
              check("S1 c4 if_done", 32'(act_ifd), 32'(3'b100)); advance();
    sample(); check("S1 c5 if_done", 32'(act_ifd), 32'(3'b001)); advance();
    sample(); check("S1 c6 busy", 32'(act_busy), 32'(3'b000)); advance();

    // Load with d_req dropped in the first DREAD cycle, then a store, then a fetch.
    do_reset();
    drive(1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF);
    sample(); advance();
    drive(1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF);
    sample(); check("S2 c1 IorD", 32'(act_iord), 32'(3'b111));
              check("S2 c1 MemRead", 32'(act_mrd), 32'(3'b111)); advance();
    sample(); check("S2 c2 d_done", 32'(act_dd), 32'(3'b001)); advance();
    sample(); check("S2 c3 d_done", 32'(act_dd), 32'(3'b010));
              check("S2 c3 d_rdata L0", act_rdata[0], 32'hDEAD_BEEF); advance();
    sample(); check("S2 c4 d_done", 32'(act_dd), 32'(3'b100));
              check("S2 c4 busy", 32'(act_busy), 32'(3'b100)); advance();
    sample(); check("S2 c5 busy", 32'(act_busy), 32'(3'b000));
              check("S2 c5 d_rdata L2", act_rdata[2], 32'hDEAD_BEEF); advance();
    drive(1'b0, 1'b1, 1'b1, 32'h1234_5678);
    sample(); advance();
    drive(1'b0, 1'b0, 1'b1, 32'h1234_5678);
    sample(); check("S2 c7 MemWrite", 32'(act_mwr), 32'(3'b111));
              check("S2 c7 d_done", 32'(act_dd), 32'(3'b111));
              check("S2 c7 MemRead", 32'(act_mrd), 32'(3'b000)); advance();
    sample(); check("S2 c8 MemWrite", 32'(act_mwr), 32'(3'b000)); advance();
    cyc(1'b1, 1'b0, 1'b0, 32'hCAFE_F00D);
    repeat (6) cyc(1'b0, 1'b0, 1'b0, 32'hCAFE_F00D);
    sample();
    for (int l = 0; l < NL; l++) check($sformatf("S2 MDR kept L%0d", l), act_rdata[l], 32'hDEAD_BEEF);
    advance();

    // Starvation: fetch and loads held together.
    do_reset();
    for (int c = 0; c < 50; c++) cyc(1'b1, 1'b1, 1'b0, 32'h1000_0000 + 32'(c));
    repeat (8) cyc(1'b0, 1'b0, 1'b0, 32'd0);
    for (int l = 0; l < NL; l++) begin
      check($sformatf("S3 grant order L%0d", l), glog[l], 32'h0000_0021);
      check($sformatf("S3 grant count L%0d", l), 32'(gcnt[l] >= 10), 32'd1);
    end

    // Reset during lane 1's second FETCH cycle, then a fresh fetch.
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 32'h5555_AAAA);
    sample(); advance();
    sample(); advance();
    sample(); check("S4 c2 if_done", 32'(act_ifd), 32'(3'b001));
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("S4 async busy", 32'(act_busy), 32'(3'b000));
    check("S4 async MemRead", 32'(act_mrd), 32'(3'b000));
    check("S4 async IRWrite", 32'(act_irw), 32'(3'b000));
    advance();
    sample(); check("S4 held if_done", 32'(act_ifd), 32'(3'b000)); advance();
    rst_n = 1'b1;
    prev_busy = '0;
    sample(); check("S4 r0 busy", 32'(act_busy), 32'(3'b000)); advance();
    drive(1'b0, 1'b0, 1'b0, 32'h5555_AAAA);
    sample(); check("S4 r1 MemRead", 32'(act_mrd), 32'(3'b111)); advance();
    sample(); check("S4 r2 if_done", 32'(act_ifd), 32'(3'b001)); advance();
    sample(); check("S4 r3 if_done", 32'(act_ifd), 32'(3'b010)); advance();
    sample(); check("S4 r4 if_done", 32'(act_ifd), 32'(3'b100)); advance();
    sample(); check("S4 r5 busy", 32'(act_busy), 32'(3'b000)); advance();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
